// File: rtl/mul_accumulator_if.sv
// mul_accumulator_if: product input stream and result output stream of the MAC back end
interface mul_accumulator_if #(
  parameter int SIZE  = 16,
  parameter int ACC_W = 40
);
  logic [2*SIZE-1:0] product;
  logic              valid;
  logic              last;
  logic              ready;
  logic [ACC_W-1:0]  acc;
  logic [7:0]        count;
  logic              overflow;
  logic              res_valid;
  logic              res_ready;
  modport master (output product, valid, last, res_ready, input ready, acc, count, overflow, res_valid);
  modport slave  (input product, valid, last, res_ready, output ready, acc, count, overflow, res_valid);
endinterface

// File: rtl/mul_accumulator.sv
// mul_accumulator: sums a run of unsigned products into a wide, optionally saturating accumulator
module mul_accumulator #(
  parameter int SIZE      = 16,
  parameter int ACC_W     = 40,
  parameter int MAX_TERMS = 255,
  parameter bit SAT       = 1'b1
) (
  input logic           clk,
  input logic           rst,
  mul_accumulator_if.slave bus
);
  typedef enum logic {ACCUM, HOLD} state_t;
  state_t           state, state_nx;
  logic [ACC_W-1:0] acc, acc_nx;
  logic [7:0]       cnt, cnt_nx;
  logic             ovf, ovf_nx;
  logic [ACC_W:0]   sum;
  logic             accept, done;
  assign bus.ready     = (state == ACCUM);
  assign bus.res_valid = (state == HOLD);
  always_comb begin
    sum      = {1'b0, acc} + (ACC_W+1)'(bus.product);
    accept   = bus.valid && state == ACCUM;
    done     = accept && (bus.last || cnt + 8'd1 == 8'(MAX_TERMS));
    acc_nx   = acc;
    cnt_nx   = cnt;
    ovf_nx   = ovf;
    state_nx = state;
    if (accept) begin
      acc_nx   = sum[ACC_W] && SAT ? '1 : sum[ACC_W-1:0];
      ovf_nx   = ovf | sum[ACC_W];
      cnt_nx   = cnt + 8'd1;
      state_nx = done ? HOLD : ACCUM;
    end
    // result handoff clears the run so the next one starts from zero
    if (state == HOLD && bus.res_ready) begin
      acc_nx   = '0;
      cnt_nx   = '0;
      ovf_nx   = 1'b0;
      state_nx = ACCUM;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ACCUM;
      acc          <= '0;
      cnt          <= '0;
      ovf          <= 1'b0;
      bus.acc      <= '0;
      bus.count    <= '0;
      bus.overflow <= 1'b0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      cnt   <= cnt_nx;
      ovf   <= ovf_nx;
      if (done) begin
        bus.acc      <= acc_nx;
        bus.count    <= cnt_nx;
        bus.overflow <= ovf_nx;
      end
    end
  end
endmodule

// File: tb/tb_mul_accumulator.sv
// tb_mul_accumulator: three configurations driven in lockstep and checked against a run-total model
module tb_mul_accumulator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] product = '0;
  logic valid = 1'b0, last = 1'b0, res_ready = 1'b0;
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  mul_accumulator_if #(.SIZE(16), .ACC_W(40)) b0 ();
  mul_accumulator_if #(.SIZE(16), .ACC_W(33)) b1 ();
  mul_accumulator_if #(.SIZE(16), .ACC_W(33)) b2 ();
  mul_accumulator u0 (.clk(clk), .rst(rst), .bus(b0.slave));
  mul_accumulator #(.SIZE(16), .ACC_W(33), .MAX_TERMS(4), .SAT(1'b1)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
  mul_accumulator #(.SIZE(16), .ACC_W(33), .MAX_TERMS(4), .SAT(1'b0)) u2 (.clk(clk), .rst(rst), .bus(b2.slave));
  assign b0.product = product; assign b0.valid = valid; assign b0.last = last; assign b0.res_ready = res_ready;
  assign b1.product = product; assign b1.valid = valid; assign b1.last = last; assign b1.res_ready = res_ready;
  assign b2.product = product; assign b2.valid = valid; assign b2.last = last; assign b2.res_ready = res_ready;
  logic [63:0] g_acc [3];
  logic [7:0]  g_cnt [3];
  logic        g_ovf [3], g_val [3], g_rdy [3];
  assign g_acc[0] = 64'(b0.acc); assign g_cnt[0] = b0.count; assign g_ovf[0] = b0.overflow; assign g_val[0] = b0.res_valid; assign g_rdy[0] = b0.ready;
  assign g_acc[1] = 64'(b1.acc); assign g_cnt[1] = b1.count; assign g_ovf[1] = b1.overflow; assign g_val[1] = b1.res_valid; assign g_rdy[1] = b1.ready;
  assign g_acc[2] = 64'(b2.acc); assign g_cnt[2] = b2.count; assign g_ovf[2] = b2.overflow; assign g_val[2] = b2.res_valid; assign g_rdy[2] = b2.ready;
  int          aw [3] = '{40, 33, 33};
  int          mt [3] = '{255, 4, 4};
  bit          sat [3] = '{1'b1, 1'b1, 1'b0};
  logic [63:0] tot [3];
  int          n [3];
  bit          busy [3];
  logic [63:0] e_acc [3];
  int          e_cnt [3];
  bit          e_ovf [3];
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  // the run is modelled as a plain total; saturation/wrap is applied once at run end
  task automatic model(bit v, bit l, logic [31:0] p, bit r);
    logic [63:0] mx;
    for (int k = 0; k < 3; k++) begin
      if (busy[k]) begin
        if (r) begin
          busy[k] = 1'b0;
          tot[k] = '0;
          n[k] = 0;
        end
      end else if (v) begin
        tot[k] += 64'(p);
        n[k]++;
        if (l || n[k] == mt[k]) begin
          mx = (64'd1 << aw[k]) - 64'd1;
          busy[k] = 1'b1;
          e_ovf[k] = tot[k] > mx;
          e_acc[k] = tot[k] > mx ? (sat[k] ? mx : tot[k] & mx) : tot[k];
          e_cnt[k] = n[k];
        end
      end
    end
  endtask
  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("ready%0d", k), 64'(g_rdy[k]), 64'(!busy[k]));
      chk($sformatf("valid%0d", k), 64'(g_val[k]), 64'(busy[k]));
      if (busy[k]) begin
        chk($sformatf("acc%0d", k), g_acc[k], e_acc[k]);
        chk($sformatf("count%0d", k), 64'(g_cnt[k]), 64'(e_cnt[k]));
        chk($sformatf("ovf%0d", k), 64'(g_ovf[k]), 64'(e_ovf[k]));
      end
    end
  endtask
  task automatic rst_check();
    for (int k = 0; k < 3; k++) begin
      busy[k] = 1'b0;
      tot[k] = '0;
      n[k] = 0;
      chk($sformatf("rst_acc%0d", k), g_acc[k], 64'd0);
      chk($sformatf("rst_count%0d", k), 64'(g_cnt[k]), 64'd0);
      chk($sformatf("rst_ovf%0d", k), 64'(g_ovf[k]), 64'd0);
      chk($sformatf("rst_valid%0d", k), 64'(g_val[k]), 64'd0);
      chk($sformatf("rst_ready%0d", k), 64'(g_rdy[k]), 64'd1);
    end
  endtask
  task automatic cyc(bit v, bit l, logic [31:0] p, bit r);
    valid = v;
    last = l;
    product = p;
    res_ready = r;
    @(posedge clk);
    model(v, l, p, r);
    #1;
    check_all();
  endtask
  task automatic async_reset();
    #2 rst = 1'b1;
    #1 rst_check();
    #1 rst = 1'b0;
  endtask
  initial begin
    #1 rst_check();
    @(negedge clk) rst = 1'b0;
    cyc(1, 0, 32'd3, 0);
    cyc(1, 0, 32'd5, 0);
    cyc(1, 1, 32'd7, 0);
    cyc(0, 0, 32'd0, 0);
    cyc(0, 0, 32'd0, 1);
    cyc(1, 1, 32'd9, 0);
    cyc(0, 0, 32'd0, 1);
    cyc(1, 0, 32'hFFFF_FFFF, 0);
    cyc(1, 0, 32'hFFFF_FFFF, 0);
    cyc(1, 1, 32'hFFFF_FFFF, 0);
    cyc(0, 0, 32'd0, 1);
    for (int i = 1; i <= 4; i++) cyc(1, 0, 32'(i), 0);
    repeat (10) cyc(1, 0, 32'd5, 0);
    cyc(1, 0, 32'd5, 1);
    cyc(1, 1, 32'd5, 0);
    cyc(0, 0, 32'd0, 1);
    cyc(0, 0, 32'd0, 1);
    cyc(1, 0, 32'd3, 0);
    cyc(1, 0, 32'd5, 0);
    async_reset();
    cyc(1, 1, 32'd9, 0);
    async_reset();
    cyc(1, 0, 32'd2, 0);
    cyc(1, 1, 32'd2, 0);
    cyc(0, 0, 32'd0, 1);
    for (int i = 0; i < 500; i++)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 3) == 0 ? 32'hFFFF_FFFF - $urandom_range(0, 15) : $urandom,
          $urandom_range(0, 1) == 1);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
